uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Consumes complete received UART messages from the receive-side message buffer (outputs FIFO_Q, MSG_LEN, PARITY_OUT, GOT_FULL_MESSAGE) and converts them into register-write transactions on a local write bus.
- Drives the buffer's MSG_START and RD_REQ strobes.
- Checks parity and the command byte, then writes the payload or drains the message.
- Reports status per message and keeps a count of good messages.

Parameters:
- TIMEOUT_CYC, 65535: maximum cycles WR_EN may wait for WR_READY before the transaction is abandoned.
- CNT_W, 16: width of the good-message counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- GOT_FULL_MESSAGE  in  1  level; high while at least one unconsumed complete message is buffered.
- MSG_LEN  in  8  byte length of the head message; valid while GOT_FULL_MESSAGE is high.
- PARITY_OUT  in  1  1 = parity error in the head message; valid while GOT_FULL_MESSAGE is high.
- FIFO_Q  in  16  message word; first received byte in [15:8]; valid the cycle after RD_REQ.
- MSG_START  out  1  one-cycle pulse; claims the head message.
- RD_REQ  out  1  one-cycle pop of one 16-bit word.
- WR_EN  out  1  write request; held until WR_READY.
- WR_ADDR  out  8  write address.
- WR_DATA  out  16  write data.
- WR_READY  in  1  write accepted when WR_EN && WR_READY.
- BUSY  out  1  high in every state except IDLE.
- MSG_DONE  out  1  one-cycle pulse when a message is fully consumed.
- ERR_CODE  out  2  status, updated with MSG_DONE: 0 ok, 1 parity, 2 bad command or length, 3 write timeout.
- MSG_CNT  out  CNT_W  count of messages finished with ERR_CODE 0; wraps.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE.
- Message format:
  - Word 0 is the header {CMD[7:0], ADDR[7:0]}; the remaining words are payload.
  - Word count is WORDS = (MSG_LEN+1)>>1, computed in 8 bits.
  - For odd MSG_LEN, WR_DATA[7:0] of the final payload word is forced to 0x00.
- Commands:
  - 0x01 WRITE_INC: each payload word is written to ADDR, ADDR+1, and so on. The address wraps from 0xFF to 0x00.
  - 0x02 WRITE_FIX: every payload word is written to ADDR.
  - Any other command is an error.
- FSM states and transitions:
  - IDLE: when GOT_FULL_MESSAGE=1, pulse MSG_START; latch MSG_LEN, PARITY_OUT and WORDS; go to HDR_RQ.
  - HDR_RQ:
    - If MSG_LEN==0: ERR_CODE=2, go to DONE; no RD_REQ is issued.
    - Otherwise: RD_REQ=1 for one cycle, then go to HDR_WT.
  - HDR_WT: capture CMD and ADDR from FIFO_Q; left = WORDS-1. Checks in priority order:
    - Latched parity error: ERR_CODE=1, go to DRAIN.
    - Bad command or MSG_LEN<3: ERR_CODE=2, go to DRAIN.
    - Otherwise go to DAT_RQ.
  - DAT_RQ: RD_REQ=1, then go to DAT_WT.
  - DAT_WT: load WR_DATA from FIFO_Q and load WR_ADDR; assert WR_EN; left decrements; go to WR_HOLD.
  - WR_HOLD:
    - WR_EN, WR_ADDR and WR_DATA stay stable until WR_READY.
    - On accept, drop WR_EN the next cycle and step the address (WRITE_INC only).
    - Then go to DONE if left==0, otherwise go to DAT_RQ.
    - Timeout: the timer starts at 0 on WR_HOLD entry. If it reaches TIMEOUT_CYC without an accept, drop WR_EN, set ERR_CODE=3 and go to DRAIN. WR_READY arriving in that same cycle counts as an accept.
  - DRAIN: issue RD_REQ pulses on alternate cycles until left==0, then go to DONE. The message is always fully popped.
  - DONE:
    - Pulse MSG_DONE and present ERR_CODE.
    - If ERR_CODE is 0, increment MSG_CNT.
    - Go to GUARD.
  - GUARD: one idle cycle so GOT_FULL_MESSAGE can update; then go to IDLE.
- Read pacing: RD_REQ is never asserted on two consecutive cycles.
- Handshake: WR_EN is never asserted outside WR_HOLD.
- Input sampling: GOT_FULL_MESSAGE is ignored outside IDLE; message inputs are sampled only in IDLE.
- Reset mid-message: return to IDLE immediately and clear all outputs. The partly read message is not recovered; the upstream buffer is reset on the same RST.
- Back-to-back messages: a new message can start 2 cycles after MSG_DONE.

Test Plan:
- WRITE_INC, MSG_LEN=6, bytes 01 10 AA BB CC DD, WR_READY tied 1 -> writes 0x10=0xAABB and 0x11=0xCCDD; MSG_DONE with ERR_CODE=0; MSG_CNT=1; exactly 3 RD_REQ.
- WRITE_FIX, MSG_LEN=5, bytes 02 FF 12 34 56 -> writes 0xFF=0x1234 and 0xFF=0x5600; 3 RD_REQ.
- WRITE_INC at ADDR=0xFF with 2 words -> addresses 0xFF then 0x00.
- PARITY_OUT=1 with MSG_LEN=8 -> no WR_EN; 4 RD_REQ; ERR_CODE=1; MSG_CNT unchanged.
- CMD=0x07, then a second valid message already pending -> ERR_CODE=2; second message starts 2 cycles after MSG_DONE.
- WR_READY held 0 with TIMEOUT_CYC=8 -> WR_EN drops after 8 cycles; remaining words drained; ERR_CODE=3.
- RST low during WR_HOLD -> WR_EN=0 asynchronously; BUSY=0.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: message-buffer read port plus local register-write bus
interface uart_cmd_decoder_if;
  logic        got_full_message;
  logic [7:0]  msg_len;
  logic        parity_out;
  logic [15:0] fifo_q;
  logic        msg_start;
  logic        rd_req;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  modport master (
    input  got_full_message, msg_len, parity_out, fifo_q, wr_ready,
    output msg_start, rd_req, wr_en, wr_addr, wr_data
  );
  modport slave (
    output got_full_message, msg_len, parity_out, fifo_q, wr_ready,
    input  msg_start, rd_req, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns buffered UART messages into register writes with status and good-message count
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_cmd_decoder_if.master bus,
  output logic             busy,
  output logic             msg_done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] msg_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {IDLE, HDR_RQ, HDR_WT, DAT_RQ, DAT_WT, WR_HOLD, DRAIN, DONE, GUARD} state_t;
  state_t state, state_n;
  logic [7:0] len_q, len_n, words, words_n, left, left_n, cmd, cmd_n, addr, addr_n, wr_addr_n;
  logic par_q, par_n, tg, tg_n, wr_en_n, cmd_ok;
  logic [1:0] err, err_n, err_code_n;
  logic [15:0] wr_data_n;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] msg_cnt_n;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    len_n = len_q;
    par_n = par_q;
    words_n = words;
    left_n = left;
    cmd_n = cmd;
    addr_n = addr;
    err_n = err;
    tg_n = 1'b0;
    timer_n = timer;
    wr_en_n = bus.wr_en;
    wr_addr_n = bus.wr_addr;
    wr_data_n = bus.wr_data;
    msg_cnt_n = msg_cnt;
    bus.msg_start = 1'b0;
    bus.rd_req = 1'b0;
    msg_done = 1'b0;
    cmd_ok = bus.fifo_q[15:8] == 8'h01 || bus.fifo_q[15:8] == 8'h02;
    case (state)
      IDLE: if (bus.got_full_message) begin
        bus.msg_start = rst_n;
        len_n = bus.msg_len;
        par_n = bus.parity_out;
        words_n = (bus.msg_len + 8'd1) >> 1;
        err_n = 2'd0;
        state_n = HDR_RQ;
      end
      HDR_RQ: begin
        bus.rd_req = len_q != 8'd0;
        err_n = len_q == 8'd0 ? 2'd2 : err;
        state_n = len_q == 8'd0 ? DONE : HDR_WT;
      end
      HDR_WT: begin
        cmd_n = bus.fifo_q[15:8];
        addr_n = bus.fifo_q[7:0];
        left_n = words - 8'd1;
        err_n = par_q ? 2'd1 : (!cmd_ok || len_q < 8'd3) ? 2'd2 : 2'd0;
        state_n = (par_q || !cmd_ok || len_q < 8'd3) ? DRAIN : DAT_RQ;
      end
      DAT_RQ: begin
        bus.rd_req = 1'b1;
        state_n = DAT_WT;
      end
      DAT_WT: begin
        // odd length: the final payload word carries only one real byte
        wr_data_n = {bus.fifo_q[15:8], (left == 8'd1 && len_q[0]) ? 8'h00 : bus.fifo_q[7:0]};
        wr_addr_n = addr;
        wr_en_n = 1'b1;
        left_n = left - 8'd1;
        timer_n = '0;
        state_n = WR_HOLD;
      end
      WR_HOLD: if (bus.wr_ready) begin
        wr_en_n = 1'b0;
        addr_n = cmd == 8'h01 ? addr + 8'd1 : addr;
        state_n = left == 8'd0 ? DONE : DAT_RQ;
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        wr_en_n = 1'b0;
        err_n = 2'd3;
        state_n = DRAIN;
      end else begin
        timer_n = timer + TW'(1);
      end
      DRAIN: if (left == 8'd0) begin
        state_n = DONE;
      end else if (!tg) begin
        bus.rd_req = 1'b1;
        left_n = left - 8'd1;
        tg_n = 1'b1;
      end
      DONE: begin
        msg_done = 1'b1;
        msg_cnt_n = err_code == 2'd0 ? msg_cnt + CNT_W'(1) : msg_cnt;
        state_n = GUARD;
      end
      GUARD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    err_code_n = state_n == DONE ? err_n : err_code;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      par_q <= 1'b0;
      words <= '0;
      left <= '0;
      cmd <= '0;
      addr <= '0;
      err <= '0;
      tg <= 1'b0;
      timer <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      err_code <= '0;
      msg_cnt <= '0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      par_q <= par_n;
      words <= words_n;
      left <= left_n;
      cmd <= cmd_n;
      addr <= addr_n;
      err <= err_n;
      tg <= tg_n;
      timer <= timer_n;
      bus.wr_en <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
      err_code <= err_code_n;
      msg_cnt <= msg_cnt_n;
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: buffer model drives messages; a scoreboard monitor checks writes, status and read pacing
module tb_uart_cmd_decoder;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_cmd_decoder_if bus();
  logic busy, msg_done;
  logic [1:0] err_code;
  logic [15:0] msg_cnt;
  uart_cmd_decoder #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .msg_done(msg_done), .err_code(err_code), .msg_cnt(msg_cnt)
  );
  int checks = 0, failures = 0;
  logic [7:0] m_len[$];
  logic m_par[$];
  logic [15:0] m_w[$];
  logic [7:0] bq[$];
  logic [23:0] exp_wr[$];
  logic [9:0] exp_done[$];
  int exp_to[$];
  logic ms, rs, prev_rd, bb, arm_gap, gap_chk;
  logic [23:0] ew;
  logic [9:0] ed;
  int cyc, rd_cnt, run, last_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic p);
    int n = bq.size();
    for (int i = 0; i < n; i += 2) m_w.push_back({bq[i], (i + 1 < n) ? bq[i + 1] : 8'h99});
    m_len.push_back(8'(n));
    m_par.push_back(p);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500 && exp_done.size() > 0; i++) @(posedge clk);
    if (exp_done.size() > 0) begin
      chk("done_timeout", exp_done.size(), 0);
      exp_done.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    ms = bus.msg_start;
    rs = bus.rd_req;
    @(posedge clk);
    #1;
    if (rs && m_w.size() > 0) bus.fifo_q = m_w.pop_front();
    if (ms && m_len.size() > 0) begin
      void'(m_len.pop_front());
      void'(m_par.pop_front());
    end
    bus.got_full_message = m_len.size() > 0;
    bus.msg_len = m_len.size() > 0 ? m_len[0] : 8'd0;
    bus.parity_out = m_par.size() > 0 ? m_par[0] : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      rd_cnt = 0; run = 0; prev_rd = 0; bb = 0;
    end else begin
      if (bus.rd_req) begin
        rd_cnt++;
        if (prev_rd) bb = 1;
      end
      prev_rd = bus.rd_req;
      if (bus.msg_start && gap_chk) begin
        chk("start_gap", cyc - last_done, 2);
        gap_chk = 0;
      end
      if (bus.wr_en) begin
        run++;
        if (bus.wr_ready) begin
          run = 0;
          if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, none expected", bus.wr_addr, bus.wr_data);
          end else begin
            ew = exp_wr.pop_front();
            chk("wr_addr", bus.wr_addr, ew[23:16]);
            chk("wr_data", bus.wr_data, ew[15:0]);
          end
        end
      end else if (run > 0) begin
        if (exp_to.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_drop: got wr_en dropped after %0d cycles, no timeout expected", run);
        end else chk("wr_hold_len", run, exp_to.pop_front());
        run = 0;
      end
      if (msg_done) begin
        last_done = cyc;
        if (arm_gap) begin gap_chk = 1; arm_gap = 0; end
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL msg_done_unexpected: got err_code %0d, none expected", err_code);
        end else begin
          ed = exp_done.pop_front();
          chk("err_code", err_code, ed[9:8]);
          chk("rd_count", rd_cnt, ed[7:0]);
        end
        chk("rd_b2b", bb, 0);
        rd_cnt = 0; bb = 0;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.got_full_message = 0; bus.msg_len = 0; bus.parity_out = 0; bus.fifo_q = 0; bus.wr_ready = 1;
    arm_gap = 0; gap_chk = 0; cyc = 0; last_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_msg_cnt", msg_cnt, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_msg_start", bus.msg_start, 0);
    rst_n = 1;
    // WRITE_INC, even length
    bq = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_wr.push_back({8'h10, 16'hAABB}); exp_wr.push_back({8'h11, 16'hCCDD});
    exp_done.push_back({2'd0, 8'd3});
    push_msg(0);
    wait_done();
    chk("cnt_inc", msg_cnt, 1);
    // WRITE_FIX, odd length masks the last low byte
    bq = '{8'h02, 8'hFF, 8'h12, 8'h34, 8'h56};
    exp_wr.push_back({8'hFF, 16'h1234}); exp_wr.push_back({8'hFF, 16'h5600});
    exp_done.push_back({2'd0, 8'd3});
    push_msg(0);
    wait_done();
    chk("cnt_fix", msg_cnt, 2);
    // address wrap
    bq = '{8'h01, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_wr.push_back({8'hFF, 16'h1122}); exp_wr.push_back({8'h00, 16'h3344});
    exp_done.push_back({2'd0, 8'd3});
    push_msg(0);
    wait_done();
    chk("cnt_wrap", msg_cnt, 3);
    // parity error drains all 4 words
    bq = '{8'h01, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_done.push_back({2'd1, 8'd4});
    push_msg(1);
    wait_done();
    chk("cnt_parity", msg_cnt, 3);
    // bad command with a good message already queued behind it
    arm_gap = 1;
    bq = '{8'h07, 8'h20, 8'h01, 8'h02};
    exp_done.push_back({2'd2, 8'd2});
    push_msg(0);
    bq = '{8'h01, 8'h30, 8'h55, 8'h66};
    exp_wr.push_back({8'h30, 16'h5566});
    exp_done.push_back({2'd0, 8'd2});
    push_msg(0);
    wait_done();
    chk("cnt_badcmd", msg_cnt, 4);
    // zero length: no reads at all
    bq.delete();
    exp_done.push_back({2'd2, 8'd0});
    push_msg(0);
    wait_done();
    // header only (length below 3)
    bq = '{8'h01, 8'h60};
    exp_done.push_back({2'd2, 8'd1});
    push_msg(0);
    wait_done();
    chk("cnt_short", msg_cnt, 4);
    // write timeout then drain remaining words
    bus.wr_ready = 0;
    bq = '{8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_to.push_back(TO);
    exp_done.push_back({2'd3, 8'd4});
    push_msg(0);
    wait_done();
    chk("cnt_timeout", msg_cnt, 4);
    // async reset while a write is pending
    bq = '{8'h01, 8'h70, 8'h11, 8'h22};
    push_msg(0);
    for (int i = 0; i < 50 && !bus.wr_en; i++) @(posedge clk);
    chk("wr_en_seen", bus.wr_en, 1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_msg_cnt", msg_cnt, 0);
    m_len.delete(); m_par.delete(); m_w.delete();
    exp_wr.delete(); exp_done.delete(); exp_to.delete();
    repeat (2) @(posedge clk);
    #1;
    bus.wr_ready = 1;
    rst_n = 1;
    // recovery after reset
    bq = '{8'h02, 8'h80, 8'hAB, 8'hCD};
    exp_wr.push_back({8'h80, 16'hABCD});
    exp_done.push_back({2'd0, 8'd2});
    push_msg(0);
    wait_done();
    chk("cnt_recover", msg_cnt, 1);
    chk("wr_left", exp_wr.size(), 0);
    chk("to_left", exp_to.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
